// File: rtl/pc_sequencer.sv
// Multi-cycle control sequencer: drives PC unit, ALU, register file and memory port per instruction.
// Latency: 2 (j/illegal), 3 (beq), 4 (R-type/ori/lui/sw), 5 (lw) cycles plus one per memory wait cycle.
// Backpressure: MemReq holds and the state stalls while MemReady is low in FETCH or MEM.
module pc_sequencer (
  input  logic        Clk,
  input  logic        ReSet_n,
  input  logic [5:0]  Op,
  input  logic [5:0]  Funct,
  input  logic        Zero,
  input  logic        MemReady,
  input  logic        Halt,
  output logic        MemReq,
  output logic        MemWe,
  output logic        IorD,
  output logic        IrWr,
  output logic        PcEn,
  output logic        PcSel,
  output logic        Jump,
  output logic        AluSrc,
  output logic [1:0]  AluOp,
  output logic        RegWr,
  output logic        RegDst,
  output logic        MemToReg,
  output logic        Illegal,
  output logic [2:0]  State,
  output logic [31:0] InstrCnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_ORLUI = 2'b11;

  state_e      state_q, state_d;
  // Set once a fetch request is on the bus, so a late Halt cannot withdraw it.
  logic        fetch_busy_q, fetch_busy_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;

  logic is_rtype, is_j, is_beq, is_ori, is_lui, is_lw, is_sw, is_legal;

  // Opcode classification; unknown funct values still run as R-type.
  always_comb begin
    is_rtype = (Op == OP_RTYPE);
    is_j     = (Op == OP_J);
    is_beq   = (Op == OP_BEQ);
    is_ori   = (Op == OP_ORI);
    is_lui   = (Op == OP_LUI);
    is_lw    = (Op == OP_LW);
    is_sw    = (Op == OP_SW);
    is_legal = is_rtype | is_j | is_beq | is_ori | is_lui | is_lw | is_sw;
  end

  // Next-state and control outputs; everything is forced low while reset is asserted.
  always_comb begin
    state_d      = state_q;
    fetch_busy_d = fetch_busy_q;
    MemReq       = 1'b0;
    MemWe        = 1'b0;
    IorD         = 1'b0;
    IrWr         = 1'b0;
    PcEn         = 1'b0;
    PcSel        = 1'b0;
    Jump         = 1'b0;
    AluSrc       = 1'b0;
    AluOp        = ALU_ADD;
    RegWr        = 1'b0;
    RegDst       = 1'b0;
    MemToReg     = 1'b0;
    Illegal      = 1'b0;

    if (ReSet_n) begin
      case (state_q)
        S_FETCH: begin
          if (!Halt || fetch_busy_q) begin
            MemReq = 1'b1;
            if (MemReady) begin
              IrWr         = 1'b1;
              fetch_busy_d = 1'b0;
              state_d      = S_DECODE;
            end else begin
              fetch_busy_d = 1'b1;
            end
          end
        end

        S_DECODE: begin
          if (is_j) begin
            PcEn    = 1'b1;
            Jump    = 1'b1;
            state_d = S_FETCH;
          end else if (!is_legal) begin
            PcEn    = 1'b1;
            Illegal = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_EXEC;
          end
        end

        S_EXEC: begin
          if (is_beq) begin
            AluOp   = ALU_SUB;
            PcEn    = 1'b1;
            PcSel   = Zero;
            state_d = S_FETCH;
          end else if (is_lw || is_sw) begin
            AluSrc  = 1'b1;
            AluOp   = ALU_ADD;
            state_d = S_MEM;
          end else if (is_rtype) begin
            AluOp   = ALU_FUNCT;
            state_d = S_WB;
          end else if (is_ori || is_lui) begin
            AluSrc  = 1'b1;
            AluOp   = ALU_ORLUI;
            state_d = S_WB;
          end else begin
            // Unreachable with a stable Op; recover to a clean fetch.
            state_d = S_FETCH;
          end
        end

        S_MEM: begin
          if (is_lw || is_sw) begin
            MemReq = 1'b1;
            IorD   = 1'b1;
            MemWe  = is_sw;
            if (MemReady) begin
              if (is_sw) begin
                PcEn    = 1'b1;
                state_d = S_FETCH;
              end else begin
                state_d = S_WB;
              end
            end
          end else begin
            state_d = S_FETCH;
          end
        end

        S_WB: begin
          RegWr    = 1'b1;
          PcEn     = 1'b1;
          RegDst   = is_rtype;
          MemToReg = is_lw;
          state_d  = S_FETCH;
        end

        default: begin
          state_d      = S_FETCH;
          fetch_busy_d = 1'b0;
        end
      endcase
    end
  end

  // Retired count advances on the single PC strobe of each instruction and wraps naturally.
  always_comb begin
    instr_cnt_d = instr_cnt_q + 32'(PcEn);
  end

  // State, fetch-in-flight flag and retired counter registers.
  always_ff @(posedge Clk or negedge ReSet_n) begin
    if (!ReSet_n) begin
      state_q      <= S_FETCH;
      fetch_busy_q <= 1'b0;
      instr_cnt_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      fetch_busy_q <= fetch_busy_d;
      instr_cnt_q  <= instr_cnt_d;
    end
  end

  assign State    = state_q;
  assign InstrCnt = instr_cnt_q;

  // The instruction register must hold Op/Funct steady once decoding has started.
  a_ir_stable : assert property (@(posedge Clk) disable iff (!ReSet_n)
    (state_q inside {S_EXEC, S_MEM, S_WB}) |-> ($stable(Op) && $stable(Funct)));

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: per-cycle expected outputs queued per instruction, popped and compared each cycle.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled 4 units later.
// Backpressure: MemReady wait cycles and Halt are scripted into each queued cycle entry.
module tb_pc_sequencer;

  logic        Clk;
  logic        ReSet_n;
  logic [5:0]  Op;
  logic [5:0]  Funct;
  logic        Zero;
  logic        MemReady;
  logic        Halt;
  logic        MemReq, MemWe, IorD, IrWr, PcEn, PcSel, Jump, AluSrc;
  logic [1:0]  AluOp;
  logic        RegWr, RegDst, MemToReg, Illegal;
  logic [2:0]  State;
  logic [31:0] InstrCnt;

  pc_sequencer dut (
    .Clk      (Clk),
    .ReSet_n  (ReSet_n),
    .Op       (Op),
    .Funct    (Funct),
    .Zero     (Zero),
    .MemReady (MemReady),
    .Halt     (Halt),
    .MemReq   (MemReq),
    .MemWe    (MemWe),
    .IorD     (IorD),
    .IrWr     (IrWr),
    .PcEn     (PcEn),
    .PcSel    (PcSel),
    .Jump     (Jump),
    .AluSrc   (AluSrc),
    .AluOp    (AluOp),
    .RegWr    (RegWr),
    .RegDst   (RegDst),
    .MemToReg (MemToReg),
    .Illegal  (Illegal),
    .State    (State),
    .InstrCnt (InstrCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Control vector order: MemReq MemWe IorD IrWr PcEn PcSel Jump AluSrc AluOp[1:0] RegWr RegDst MemToReg Illegal
  localparam logic [13:0] C_MEMREQ = 14'h2000;
  localparam logic [13:0] C_MEMWE  = 14'h1000;
  localparam logic [13:0] C_IORD   = 14'h0800;
  localparam logic [13:0] C_IRWR   = 14'h0400;
  localparam logic [13:0] C_PCEN   = 14'h0200;
  localparam logic [13:0] C_PCSEL  = 14'h0100;
  localparam logic [13:0] C_JUMP   = 14'h0080;
  localparam logic [13:0] C_ALUSRC = 14'h0040;
  localparam logic [13:0] C_AOP01  = 14'h0010;
  localparam logic [13:0] C_AOP10  = 14'h0020;
  localparam logic [13:0] C_AOP11  = 14'h0030;
  localparam logic [13:0] C_REGWR  = 14'h0008;
  localparam logic [13:0] C_REGDST = 14'h0004;
  localparam logic [13:0] C_M2R    = 14'h0002;
  localparam logic [13:0] C_ILL    = 14'h0001;

  logic [13:0] act_ctrl;
  assign act_ctrl = {MemReq, MemWe, IorD, IrWr, PcEn, PcSel, Jump, AluSrc,
                     AluOp, RegWr, RegDst, MemToReg, Illegal};

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mr;
    logic        halt;
    logic [2:0]  st;
    logic [13:0] ctrl;
    logic [31:0] cnt;
  } ent_t;

  ent_t        sb[$];
  int          n_cmp;
  int          n_err;
  logic [31:0] exp_cnt;
  logic [5:0]  g_op, g_funct;
  logic        g_zero;

  // Queue one expected cycle; the stimulus for that cycle travels with it.
  task automatic push(input logic [2:0] st, input logic [13:0] c, input logic mr, input logic hl);
    ent_t e;
    e.op = g_op; e.funct = g_funct; e.zero = g_zero;
    e.mr = mr; e.halt = hl; e.st = st; e.ctrl = c; e.cnt = exp_cnt;
    sb.push_back(e);
    if ((c & C_PCEN) != 14'h0) exp_cnt = exp_cnt + 32'd1;
  endtask

  // Expected cycle sequence of one instruction. fw/mw = wait cycles in FETCH/MEM; hl = Halt after the request is up.
  task automatic push_instr(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                            input int fw, input int mw, input logic hl);
    logic [13:0] mc;
    g_op = op; g_funct = funct; g_zero = zero;
    for (int i = 0; i < fw; i++) push(3'd0, C_MEMREQ, 1'b0, (i == 0) ? 1'b0 : hl);
    push(3'd0, C_MEMREQ | C_IRWR, 1'b1, (fw == 0) ? 1'b0 : hl);
    case (op)
      6'h02: push(3'd1, C_PCEN | C_JUMP, 1'($urandom), 1'($urandom));
      6'h04: begin
        push(3'd1, 14'h0, 1'($urandom), 1'($urandom));
        push(3'd2, C_AOP01 | C_PCEN | (zero ? C_PCSEL : 14'h0), 1'($urandom), 1'($urandom));
      end
      6'h23, 6'h2B: begin
        mc = C_MEMREQ | C_IORD | ((op == 6'h2B) ? C_MEMWE : 14'h0);
        push(3'd1, 14'h0, 1'($urandom), 1'($urandom));
        push(3'd2, C_ALUSRC, 1'($urandom), 1'($urandom));
        for (int i = 0; i < mw; i++) push(3'd3, mc, 1'b0, 1'($urandom));
        if (op == 6'h2B) push(3'd3, mc | C_PCEN, 1'b1, 1'($urandom));
        else begin
          push(3'd3, mc, 1'b1, 1'($urandom));
          push(3'd4, C_REGWR | C_PCEN | C_M2R, 1'($urandom), 1'($urandom));
        end
      end
      6'h00: begin
        push(3'd1, 14'h0, 1'($urandom), 1'($urandom));
        push(3'd2, C_AOP10, 1'($urandom), 1'($urandom));
        push(3'd4, C_REGWR | C_PCEN | C_REGDST, 1'($urandom), 1'($urandom));
      end
      6'h0D, 6'h0F: begin
        push(3'd1, 14'h0, 1'($urandom), 1'($urandom));
        push(3'd2, C_ALUSRC | C_AOP11, 1'($urandom), 1'($urandom));
        push(3'd4, C_REGWR | C_PCEN, 1'($urandom), 1'($urandom));
      end
      default: push(3'd1, C_PCEN | C_ILL, 1'($urandom), 1'($urandom));
    endcase
  endtask

  // Pop n queued cycles, drive their stimulus and compare the DUT. Entered and left at posedge+1.
  task automatic run_n(input int n);
    ent_t e;
    for (int i = 0; i < n; i++) begin
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL scoreboard_underflow: queue empty, required %0d more entries", n - i);
        return;
      end
      e = sb.pop_front();
      Op = e.op; Funct = e.funct; Zero = e.zero; MemReady = e.mr; Halt = e.halt;
      #4;
      n_cmp++;
      if (State !== e.st) begin
        n_err++;
        $display("FAIL state @%0t: got %0d, expected %0d", $time, State, e.st);
      end
      n_cmp++;
      if (act_ctrl !== e.ctrl) begin
        n_err++;
        $display("FAIL ctrl @%0t (state %0d): got %h, expected %h", $time, e.st, act_ctrl, e.ctrl);
      end
      n_cmp++;
      if (InstrCnt !== e.cnt) begin
        n_err++;
        $display("FAIL instr_cnt @%0t: got %0d, expected %0d", $time, InstrCnt, e.cnt);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic run_all();
    run_n(sb.size());
  endtask

  task automatic check_cnt(input string name);
    n_cmp++;
    if (InstrCnt !== exp_cnt) begin
      n_err++;
      $display("FAIL %s: InstrCnt got %0d, expected %0d", name, InstrCnt, exp_cnt);
    end
  endtask

  task automatic test_reset();
    ReSet_n = 1'b0; Halt = 1'b0; MemReady = 1'b1; Op = 6'h23; Funct = 6'h00; Zero = 1'b0;
    exp_cnt = 32'd0;
    #3;
    n_cmp++;
    if (State !== 3'd0 || InstrCnt !== 32'd0 || act_ctrl !== 14'h0) begin
      n_err++;
      $display("FAIL reset_state: State=%0d InstrCnt=%0d ctrl=%h, expected 0/0/0000", State, InstrCnt, act_ctrl);
    end
    repeat (2) @(posedge Clk);
    #1;
    n_cmp++;
    if (act_ctrl !== 14'h0) begin
      n_err++;
      $display("FAIL reset_hold_ctrl: got %h, expected 0000", act_ctrl);
    end
    ReSet_n = 1'b1;
  endtask

  task automatic test_lw();
    push_instr(6'h23, 6'h00, 1'b0, 0, 0, 1'b0);
    run_all();
    check_cnt("lw_count");
  endtask

  task automatic test_beq();
    push_instr(6'h04, 6'h00, 1'b1, 0, 0, 1'b0);
    push_instr(6'h04, 6'h00, 1'b0, 2, 0, 1'b0);
    run_all();
    check_cnt("beq_count");
  endtask

  task automatic test_j_illegal();
    push_instr(6'h02, 6'h00, 1'b0, 0, 0, 1'b0);
    push_instr(6'h3F, 6'h00, 1'b0, 0, 0, 1'b0);
    push_instr(6'h11, 6'h00, 1'b0, 1, 0, 1'b0);
    run_all();
    check_cnt("j_illegal_count");
  endtask

  task automatic test_rtype_imm();
    push_instr(6'h00, 6'h21, 1'b0, 0, 0, 1'b0);
    push_instr(6'h00, 6'h23, 1'b0, 0, 0, 1'b0);
    push_instr(6'h00, 6'h3A, 1'b1, 0, 0, 1'b0);
    push_instr(6'h0D, 6'h00, 1'b0, 0, 0, 1'b0);
    push_instr(6'h0F, 6'h00, 1'b0, 1, 0, 1'b0);
    run_all();
    check_cnt("rtype_imm_count");
  endtask

  task automatic test_sw_wait();
    push_instr(6'h2B, 6'h00, 1'b0, 0, 3, 1'b0);
    run_all();
    check_cnt("sw_wait_count");
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [11];
    logic [5:0] fns [11];
    int k;
    ops = '{6'h00, 6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F, 6'h11};
    fns = '{6'h21, 6'h23, 6'h3F, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    for (int i = 0; i < 24; i++) begin
      k = int'($urandom_range(0, 10));
      push_instr(ops[k], fns[k], 1'($urandom), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 2)), 1'($urandom));
    end
    run_all();
    check_cnt("back_to_back_count");
  endtask

  task automatic test_reset_abort();
    // lw with MEM stalled: FETCH, DECODE, EXEC, first MEM wait cycle, then reset in the second.
    push_instr(6'h23, 6'h00, 1'b0, 0, 3, 1'b0);
    run_n(4);
    MemReady = 1'b0;
    #1 ReSet_n = 1'b0;
    #1;
    n_cmp++;
    if (State !== 3'd0 || InstrCnt !== 32'd0) begin
      n_err++;
      $display("FAIL abort_reset_state: State=%0d InstrCnt=%0d, expected 0/0", State, InstrCnt);
    end
    n_cmp++;
    if (act_ctrl !== 14'h0) begin
      n_err++;
      $display("FAIL abort_reset_ctrl: got %h, expected 0000", act_ctrl);
    end
    sb.delete();
    exp_cnt = 32'd0;
    MemReady = 1'b1;
    @(posedge Clk); #1;
    n_cmp++;
    if (RegWr !== 1'b0 || PcEn !== 1'b0) begin
      n_err++;
      $display("FAIL abort_no_retire: RegWr=%b PcEn=%b, expected 0/0", RegWr, PcEn);
    end
    Halt = 1'b1;
    @(posedge Clk); #1;
    ReSet_n = 1'b1;
  endtask

  task automatic test_halt();
    g_op = 6'h23; g_funct = 6'h00; g_zero = 1'b0;
    for (int i = 0; i < 8; i++) push(3'd0, 14'h0, 1'($urandom), 1'b1);
    run_all();
    // Halt rising after the fetch request is already up must not cancel it.
    push_instr(6'h0D, 6'h00, 1'b0, 3, 0, 1'b1);
    run_all();
    check_cnt("halt_count");
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_lw();
    test_beq();
    test_j_illegal();
    test_rtype_imm();
    test_sw_wait();
    test_back_to_back();
    test_reset_abort();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle control FSM that sequences the program counter unit and the surrounding single-port-memory datapath through fetch, decode, execute, memory and write-back steps. It issues exactly one PC-update strobe per instruction, with the branch/jump selects valid in the same cycle, and counts retired instructions. It sits between the instruction register and the PC unit, ALU, register file and memory interface.

## Interface
- No parameters.
- Clk  input  1  system clock; all state changes on rising edge.
- ReSet_n  input  1  asynchronous, active-low reset.
- Op  input  6  opcode from the external instruction register; stable from DECODE to end of instruction.
- Funct  input  6  funct field from the instruction register.
- Zero  input  1  ALU zero flag, sampled in EXEC.
- MemReady  input  1  memory done for the current request; may be high in the request's first cycle.
- Halt  input  1  when high on FETCH entry, no fetch is issued.
- MemReq  output  1  memory request, held until MemReady.
- MemWe  output  1  write qualifier for MemReq.
- IorD  output  1  0 = instruction address (PC), 1 = data address (ALU result).
- IrWr  output  1  load instruction register.
- PcEn  output  1  one-cycle PC update strobe.
- PcSel  output  1  branch-offset select, valid only with PcEn.
- Jump  output  1  jump-target select, valid only with PcEn.
- AluSrc  output  1  0 = register, 1 = immediate.
- AluOp  output  2  00 add, 01 sub, 10 funct-decoded, 11 or/lui.
- RegWr  output  1  register-file write.
- RegDst  output  1  1 = rd, 0 = rt.
- MemToReg  output  1  write-back from memory.
- Illegal  output  1  one-cycle pulse on an unsupported opcode.
- State  output  3  current state encoding.
- InstrCnt  output  32  retired-instruction count.

## Operation
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- Supported opcodes: R-type 0x00 (funct 0x21 addu, 0x23 subu), ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, j 0x02. Unsupported R-type funct values are executed as R-type with AluOp=10.
- FETCH:
  - If Halt is high, the block idles with all outputs 0.
  - Otherwise it asserts MemReq with IorD=0 and MemWe=0.
  - On MemReady it asserts IrWr the same cycle and moves to DECODE.
- DECODE:
  - j: PcEn=1, Jump=1, then FETCH.
  - Illegal opcode: PcEn=1, Illegal=1, then FETCH.
  - All other opcodes go to EXEC.
- EXEC:
  - beq: AluOp=01, PcEn=1, PcSel=Zero, then FETCH.
  - lw/sw: AluSrc=1, AluOp=00, then MEM.
  - R-type: AluOp=10, then WB.
  - ori/lui: AluSrc=1, AluOp=11, then WB.
- MEM:
  - MemReq=1, IorD=1, MemWe=1 for sw.
  - On MemReady: lw goes to WB; sw asserts PcEn and goes to FETCH.
- WB:
  - RegWr=1, PcEn=1, then FETCH.
  - RegDst=1 for R-type only; MemToReg=1 for lw only.
- InstrCnt increments by 1 in every cycle where PcEn=1, including illegal opcodes. It wraps from 0xFFFF_FFFF to 0.
- All control outputs are 0 in any state/opcode combination not listed above.

## Timing
- Reset (asynchronous, ReSet_n=0): State=FETCH, InstrCnt=0, every other output 0. The first request is issued in the first cycle after ReSet_n rises, unless Halt is high.
- Reset asserted mid-instruction aborts the instruction: no PcEn and no RegWr are issued. Any pending memory request is dropped.
- Cycles per instruction with zero-wait memory (MemReady high in the request's first cycle):
  - j and illegal: 2
  - beq: 3
  - R-type, ori, lui, sw: 4
  - lw: 5
- Each wait cycle (MemReady low during FETCH or MEM) adds one cycle. MemReq stays high and the state does not change.
- MemReady is ignored outside FETCH and MEM.
- Halt is sampled only in FETCH before a request is issued. Once MemReq is raised, the fetch completes regardless of Halt.
- PcEn is high for exactly one cycle per instruction. Outputs are combinational from State, Op, Funct, Zero and MemReady.

## Test plan
- Reset → State=0, InstrCnt=0, all controls 0. Release with Halt=0 → MemReq=1, IorD=0 in the next cycle.
- lw (Op=0x23), MemReady always 1 → states 0,1,2,3,4. PcEn only in cycle 5 with RegWr=1, MemToReg=1, RegDst=0. InstrCnt=1.
- beq (Op=0x04) twice: Zero=1 → PcEn=1 with PcSel=1 in cycle 3; Zero=0 → PcEn=1 with PcSel=0. InstrCnt=2.
- j (Op=0x02) → PcEn=1 and Jump=1 in DECODE, 2-cycle instruction. Op=0x3F → Illegal=1 and PcEn=1 in DECODE.
- sw with MemReady low for 3 MEM cycles → MemReq=1, MemWe=1, IorD=1 held for 4 cycles. PcEn=1 on the MemReady cycle, no RegWr.
- ReSet_n pulsed low during the MEM state of lw → immediate State=0 and InstrCnt=0; no RegWr or PcEn for the aborted lw. Halt=1 at FETCH → MemReq stays 0 indefinitely.
